// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: segment bit positions,
// the canonical hex glyph patterns, and the stability tracker states.
package seg_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Patterns are {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A_HEX = 7'b1110111;
  localparam logic [6:0] SEG_B_HEX = 7'b0011111;
  localparam logic [6:0] SEG_C_HEX = 7'b1001110;
  localparam logic [6:0] SEG_D_HEX = 7'b0111101;
  localparam logic [6:0] SEG_E_HEX = 7'b1001111;
  localparam logic [6:0] SEG_F_HEX = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {SCAN, HOLD} trk_state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display bus plus frame output handshake. The display driver / consumer
// side uses master; the decoder uses slave.
interface seg_scan_decoder_if #(parameter int NUM_DIGITS = 4);

  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    out_ready;
  logic                    out_valid;
  logic [4*NUM_DIGITS-1:0] out_value;
  logic [NUM_DIGITS-1:0]   out_err;
  logic                    overrun;

  modport master (
    output seg_in, dig_sel, out_ready,
    input  out_valid, out_value, out_err, overrun
  );

  modport slave (
    input  seg_in, dig_sel, out_ready,
    output out_valid, out_value, out_err, overrun
  );

endinterface

// File: rtl/seg_scan_decoder_decode.sv
// Combinational inverse of a hex-to-7-segment encoder. Unknown patterns,
// including blank, give nibble 0 with err set.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'h0;
    err_o    = 1'b0;
    case (pattern_i)
      SEG_0:     nibble_o = 4'h0;
      SEG_1:     nibble_o = 4'h1;
      SEG_2:     nibble_o = 4'h2;
      SEG_3:     nibble_o = 4'h3;
      SEG_4:     nibble_o = 4'h4;
      SEG_5:     nibble_o = 4'h5;
      SEG_6:     nibble_o = 4'h6;
      SEG_7:     nibble_o = 4'h7;
      SEG_8:     nibble_o = 4'h8;
      SEG_9:     nibble_o = 4'h9;
      SEG_A_HEX: nibble_o = 4'hA;
      SEG_B_HEX: nibble_o = 4'hB;
      SEG_C_HEX: nibble_o = 4'hC;
      SEG_D_HEX: nibble_o = 4'hD;
      SEG_E_HEX: nibble_o = 4'hE;
      SEG_F_HEX: nibble_o = 4'hF;
      default:   err_o    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the hex value shown on a multiplexed 7-segment display: qualifies
// each digit for stability, decodes it, and emits whole frames via valid/ready.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]              sSeg_q, prevSeg_q, accSeg_q;
  logic [NUM_DIGITS-1:0]   sSel_q, prevSel_q, accSel_q;
  trk_state_e              state_q;
  logic [CW-1:0]           cnt_q, runLen;
  logic                    accept_q, sameVal, oneHot;

  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] slotVal_q, slotVal_d, value_q;
  logic [NUM_DIGITS-1:0]   slotErr_q, slotErr_d, err_q;
  logic                    valid_q, overrun_q, frameDone;
  logic [3:0]              decNib;
  logic                    decErr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sSeg_q <= '0;
      sSel_q <= '0;
    end else begin
      sSeg_q <= bus.seg_in;
      sSel_q <= bus.dig_sel;
    end
  end

  // runLen counts the current cycle, so a fresh value is already run 1
  assign sameVal = (sSel_q == prevSel_q) && (sSeg_q == prevSeg_q);
  assign oneHot  = (sSel_q != '0) && ((sSel_q & (sSel_q - NUM_DIGITS'(1))) == '0);
  assign runLen  = !sameVal ? CW'(1) :
                   (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      prevSel_q <= '0;
      prevSeg_q <= '0;
      accept_q  <= 1'b0;
      accSel_q  <= '0;
      accSeg_q  <= '0;
    end else begin
      prevSel_q <= sSel_q;
      prevSeg_q <= sSeg_q;
      accept_q  <= 1'b0;
      if (!oneHot) begin
        state_q <= SCAN;
        cnt_q   <= '0;
      end else if (state_q == HOLD && sameVal) begin
        state_q <= HOLD;
      end else if (runLen == CW'(STABLE_CYCLES)) begin
        state_q  <= HOLD;
        cnt_q    <= runLen;
        accept_q <= 1'b1;
        accSel_q <= sSel_q;
        accSeg_q <= sSeg_q;
      end else begin
        state_q <= SCAN;
        cnt_q   <= runLen;
      end
    end
  end

  seg_pattern_decode u_decode (
    .pattern_i (accSeg_q),
    .nibble_o  (decNib),
    .err_o     (decErr)
  );

  always_comb begin
    slotVal_d = slotVal_q;
    slotErr_d = slotErr_q;
    seen_d    = seen_q;
    if (accept_q) begin
      seen_d = seen_q | accSel_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (accSel_q[i]) begin
          slotVal_d[4*i +: 4] = decNib;
          slotErr_d[i]        = decErr;
        end
      end
    end
    frameDone = accept_q && (&seen_d);
  end

  // A completing frame loads only if the output slot is free or draining now
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q    <= '0;
      slotVal_q <= '0;
      slotErr_q <= '0;
      value_q   <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      slotVal_q <= slotVal_d;
      slotErr_q <= slotErr_d;
      seen_q    <= frameDone ? '0 : seen_d;
      if (frameDone && (!valid_q || bus.out_ready)) begin
        value_q <= slotVal_d;
        err_q   <= slotErr_d;
        valid_q <= 1'b1;
      end else begin
        if (frameDone) overrun_q <= 1'b1;
        if (valid_q && bus.out_ready) valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_value = value_q;
  assign bus.out_err   = err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (4 digits, 3-cycle stability):
// drives the display bus on falling edges and checks outputs there too.
module tb_seg_scan_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;
  int   failCount = 0;

  seg_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] sel, input logic [6:0] seg, input int cycles);
    bus.dig_sel = sel;
    bus.seg_in  = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] expValue, input logic [3:0] expErr);
    checkOutput({tag, "_valid"}, 16'(bus.out_valid), 16'h1);
    checkOutput({tag, "_value"}, bus.out_value, expValue);
    checkOutput({tag, "_err"}, 16'(bus.out_err), 16'(expErr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.dig_sel   = '0;
    bus.seg_in    = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);

    // Reset with random bus activity
    rst_n = 1'b0;
    repeat (2) begin
      bus.dig_sel = 4'($urandom);
      bus.seg_in  = 7'($urandom);
      @(negedge clk);
    end
    checkOutput("rst_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("rst_value", bus.out_value, 16'h0000);
    checkOutput("rst_err", 16'(bus.out_err), 16'h0);
    checkOutput("rst_overrun", 16'(bus.overrun), 16'h0);
    bus.dig_sel = '0;
    bus.seg_in  = '0;
    rst_n = 1'b1;
    @(negedge clk);

    // Clean frame 3,4,6,A
    applyStimulus(4'b0001, 7'b1111001, 4);
    applyStimulus(4'b0010, 7'b0110011, 4);
    applyStimulus(4'b0100, 7'b1011111, 4);
    applyStimulus(4'b1000, 7'b1110111, 4);
    @(negedge clk);
    checkFrame("clean", 16'hA643, 4'b0000);
    @(negedge clk);
    checkOutput("clean_drop", 16'(bus.out_valid), 16'h0);

    // Glitch on digit 0, then a two-hot dwell that must never accept
    applyStimulus(4'b0001, 7'b1111110, 2);
    applyStimulus(4'b0001, 7'b0110000, 3);
    applyStimulus(4'b0011, 7'b1111111, 10);
    checkOutput("twohot_novalid", 16'(bus.out_valid), 16'h0);
    applyStimulus(4'b0010, 7'b1101101, 4);
    applyStimulus(4'b0100, 7'b1011011, 4);
    applyStimulus(4'b1000, 7'b1111111, 4);
    @(negedge clk);
    checkFrame("glitch", 16'h8521, 4'b0000);
    @(negedge clk);

    // Undecodable digit 2
    applyStimulus(4'b0001, 7'b1001110, 4);
    applyStimulus(4'b0010, 7'b0110000, 4);
    applyStimulus(4'b0100, 7'b0000001, 4);
    applyStimulus(4'b1000, 7'b1111110, 4);
    @(negedge clk);
    checkFrame("invalid", 16'h001C, 4'b0100);
    @(negedge clk);

    // Backpressure: second frame is dropped
    bus.out_ready = 1'b0;
    applyStimulus(4'b0001, 7'b0110000, 4);
    applyStimulus(4'b0010, 7'b1101101, 4);
    applyStimulus(4'b0100, 7'b1111001, 4);
    applyStimulus(4'b1000, 7'b0110011, 4);
    @(negedge clk);
    checkOutput("bp_first_valid", 16'(bus.out_valid), 16'h1);
    checkOutput("bp_first_value", bus.out_value, 16'h4321);
    applyStimulus(4'b0001, 7'b1011011, 4);
    applyStimulus(4'b0010, 7'b1011111, 4);
    applyStimulus(4'b0100, 7'b1110000, 4);
    applyStimulus(4'b1000, 7'b1111111, 4);
    @(negedge clk);
    checkOutput("bp_hold_valid", 16'(bus.out_valid), 16'h1);
    checkOutput("bp_hold_value", bus.out_value, 16'h4321);
    checkOutput("bp_overrun", 16'(bus.overrun), 16'h1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checkOutput("bp_release_valid", 16'(bus.out_valid), 16'h0);
    checkOutput("bp_overrun_sticky", 16'(bus.overrun), 16'h1);

    // Mid-frame reset discards digits 0 and 1
    bus.out_ready = 1'b1;
    applyStimulus(4'b0001, 7'b1111110, 4);
    applyStimulus(4'b0010, 7'b0110000, 4);
    applyStimulus(4'b0000, 7'b0000000, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_overrun", 16'(bus.overrun), 16'h0);
    applyStimulus(4'b0100, 7'b1110000, 4);
    applyStimulus(4'b1000, 7'b1000111, 4);
    applyStimulus(4'b0000, 7'b0000000, 3);
    checkOutput("mid_rst_novalid", 16'(bus.out_valid), 16'h0);
    applyStimulus(4'b0100, 7'b0111101, 4);
    applyStimulus(4'b1000, 7'b1001111, 4);
    applyStimulus(4'b0001, 7'b1111011, 4);
    applyStimulus(4'b0010, 7'b0011111, 4);
    @(negedge clk);
    checkFrame("after_rst", 16'hEDB9, 4'b0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
